// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD time/alarm display driver.
package lcd_pkg;

   // Display source selected by the FSM
   typedef enum logic [1:0] {
      S_TIME  = 2'd0,
      S_ALARM = 2'd1,
      S_KEY   = 2'd2
   } lcd_state_e;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_ERR   = 8'h2A;
   localparam logic [7:0] ASCII_BLANK = 8'h20;

endpackage

// File: rtl/lcd_digit_enc.sv
// BCD digit to ASCII character; non-decimal codes show as '*'.
module lcd_digit_enc
   import lcd_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [7:0] o_ascii
);

   // Purely combinational encode, no state here
   always_comb begin
      o_ascii = ASCII_ERR;
      if (i_bcd <= 4'd9) begin
         o_ascii = ASCII_ZERO + {4'h0, i_bcd};
      end
   end

endmodule

// File: rtl/lcd_driver_n.sv
// LCD driver: selects time / alarm / key-entry digits for display,
// blinks the key-entry view, and sounds a timed alarm on time match.
//
// state   | meaning
// --------+---------------------------------------------------
// S_TIME  | showing current_time (default)
// S_ALARM | showing alarm_time (show_alarm held)
// S_KEY   | showing keypad digits, blinking (show_new_time held)
module lcd_driver_n
   import lcd_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int BLINK_DIV    = 250,
   parameter int ALARM_CYCLES = 1000
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [4*NUM_DIGITS-1:0] alarm_time,
   input  logic [4*NUM_DIGITS-1:0] current_time,
   input  logic [4*NUM_DIGITS-1:0] key,
   input  logic                    show_alarm,
   input  logic                    show_new_time,
   input  logic                    stop_alarm,
   output logic [8*NUM_DIGITS-1:0] display_time,
   output logic                    sound_alarm
);

   localparam int BLK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam int ALM_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
   localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_DIV - 1);
   localparam logic [ALM_W-1:0] ALARM_LOAD = ALM_W'(ALARM_CYCLES - 1);

   lcd_state_e              r_state;
   lcd_state_e              w_state_nxt;
   logic [BLK_W-1:0]        r_blink_cnt;
   logic [BLK_W-1:0]        w_blink_cnt_nxt;
   logic                    r_phase_on;
   logic                    w_phase_nxt;
   logic [4*NUM_DIGITS-1:0] w_bcd_sel;
   logic [8*NUM_DIGITS-1:0] w_ascii;
   logic [8*NUM_DIGITS-1:0] w_disp_nxt;
   logic [8*NUM_DIGITS-1:0] r_display;
   logic                    w_match;
   logic                    w_match_rise;
   logic                    r_match_d;
   logic [ALM_W-1:0]        r_alarm_cnt;
   logic                    r_sound;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_TIME;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: key entry wins over alarm view
   always_comb begin
      w_state_nxt = S_TIME;
      if (show_new_time) begin
         w_state_nxt = S_KEY;
      end else if (show_alarm) begin
         w_state_nxt = S_ALARM;
      end
   end

   // Blink timing; a fresh entry into S_KEY restarts with a visible frame
   always_comb begin
      w_blink_cnt_nxt = '0;
      w_phase_nxt     = 1'b1;
      if ((w_state_nxt == S_KEY) && (r_state == S_KEY)) begin
         if (r_blink_cnt == BLINK_LAST) begin
            w_blink_cnt_nxt = '0;
            w_phase_nxt     = ~r_phase_on;
         end else begin
            w_blink_cnt_nxt = r_blink_cnt + 1'b1;
            w_phase_nxt     = r_phase_on;
         end
      end
   end

   // Source digits follow the state being entered so display has 1-cycle latency
   always_comb begin
      w_bcd_sel = current_time;
      case (w_state_nxt)
         S_KEY:   w_bcd_sel = key;
         S_ALARM: w_bcd_sel = alarm_time;
         default: w_bcd_sel = current_time;
      endcase
   end

   genvar g;
   generate
      for (g = 0; g < NUM_DIGITS; g++) begin : g_enc
         lcd_digit_enc u_enc (
            .i_bcd   (w_bcd_sel[4*g +: 4]),
            .o_ascii (w_ascii[8*g +: 8])
         );
      end
   endgenerate

   // Blank every digit during the off half of the key blink
   always_comb begin
      w_disp_nxt = w_ascii;
      if ((w_state_nxt == S_KEY) && !w_phase_nxt) begin
         w_disp_nxt = {NUM_DIGITS{ASCII_BLANK}};
      end
   end

   // Display and blink registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_display   <= {NUM_DIGITS{ASCII_ZERO}};
         r_blink_cnt <= '0;
         r_phase_on  <= 1'b1;
      end else begin
         r_display   <= w_disp_nxt;
         r_blink_cnt <= w_blink_cnt_nxt;
         r_phase_on  <= w_phase_nxt;
      end
   end

   assign w_match      = (alarm_time == current_time);
   assign w_match_rise = w_match & ~r_match_d;

   // Alarm timer; match_d resets high so an equal time at reset release is not an edge
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_match_d   <= 1'b1;
         r_sound     <= 1'b0;
         r_alarm_cnt <= '0;
      end else begin
         r_match_d <= w_match;
         if (stop_alarm) begin
            r_sound     <= 1'b0;
            r_alarm_cnt <= '0;
         end else if (w_match_rise) begin
            r_sound     <= 1'b1;
            r_alarm_cnt <= ALARM_LOAD;
         end else if (r_sound) begin
            if (r_alarm_cnt == '0) begin
               r_sound <= 1'b0;
            end else begin
               r_alarm_cnt <= r_alarm_cnt - 1'b1;
            end
         end
      end
   end

   assign display_time = r_display;
   assign sound_alarm  = r_sound;

endmodule

// File: tb/tb_lcd_driver_n.sv
// Bench for lcd_driver_n: 4-digit main instance plus 6- and 1-digit instances.
module tb_lcd_driver_n;

   logic        clock;
   logic        reset_n;
   logic        lo;

   logic [15:0] alm4, cur4, key4;
   logic        sa4, snt4, stop4;
   logic [31:0] disp4;
   logic        snd4;

   logic [23:0] alm6, cur6, key6;
   logic [47:0] disp6;
   logic        snd6;

   logic [3:0]  alm1, cur1, key1;
   logic [7:0]  disp1;
   logic        snd1;

   int n_tests = 0;
   int n_fail  = 0;

   lcd_driver_n #(.NUM_DIGITS(4), .BLINK_DIV(4), .ALARM_CYCLES(10)) dut4 (
      .clock(clock), .reset_n(reset_n), .alarm_time(alm4), .current_time(cur4),
      .key(key4), .show_alarm(sa4), .show_new_time(snt4), .stop_alarm(stop4),
      .display_time(disp4), .sound_alarm(snd4));

   lcd_driver_n #(.NUM_DIGITS(6), .BLINK_DIV(4), .ALARM_CYCLES(10)) dut6 (
      .clock(clock), .reset_n(reset_n), .alarm_time(alm6), .current_time(cur6),
      .key(key6), .show_alarm(lo), .show_new_time(lo), .stop_alarm(lo),
      .display_time(disp6), .sound_alarm(snd6));

   lcd_driver_n #(.NUM_DIGITS(1), .BLINK_DIV(4), .ALARM_CYCLES(10)) dut1 (
      .clock(clock), .reset_n(reset_n), .alarm_time(alm1), .current_time(cur1),
      .key(key1), .show_alarm(lo), .show_new_time(lo), .stop_alarm(lo),
      .display_time(disp1), .sound_alarm(snd1));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic        sa;
      logic        snt;
      logic [15:0] cur;
      logic [15:0] alm;
      logic [15:0] key;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      string       name;
      int          sig;
      logic [63:0] exp;
   } sb_t;

   // sig ids: 0 disp4, 1 snd4, 2 disp6, 3 snd6, 4 disp1, 5 snd1
   sb_t sb_q[$];
   vec_t vt[9];

   function automatic logic [63:0] actual(input int sig);
      case (sig)
         0: return {32'h0, disp4};
         1: return {63'h0, snd4};
         2: return {16'h0, disp6};
         3: return {63'h0, snd6};
         4: return {56'h0, disp1};
         default: return {63'h0, snd1};
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input string nm, input int sig, input logic [63:0] exp);
      sb_t e;
      e.name = nm;
      e.sig  = sig;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   task automatic push_snd(input string nm, input logic e4, input logic e6, input logic e1);
      push({nm, "_snd4"}, 1, {63'h0, e4});
      push({nm, "_snd6"}, 3, {63'h0, e6});
      push({nm, "_snd1"}, 5, {63'h0, e1});
   endtask

   // Advance one edge, then compare everything queued for that edge
   task automatic cycle();
      sb_t e;
      @(posedge clock);
      #1;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk(e.name, actual(e.sig), e.exp);
      end
   endtask

   initial begin
      vt[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000, 32'h31323334};
      vt[1] = '{1'b0, 1'b0, 16'h9876, 16'h0000, 16'h0000, 32'h39383736};
      vt[2] = '{1'b1, 1'b0, 16'h9876, 16'h2359, 16'h0000, 32'h32333539};
      vt[3] = '{1'b0, 1'b0, 16'hABCD, 16'h0000, 16'h0000, 32'h2A2A2A2A};
      vt[4] = '{1'b0, 1'b0, 16'h0F09, 16'h0000, 16'h0000, 32'h302A3039};
      vt[5] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 16'h0A59, 32'h302A3539};
      vt[6] = '{1'b0, 1'b1, 16'h1111, 16'h2222, 16'h3478, 32'h33343738};
      vt[7] = '{1'b1, 1'b0, 16'h1111, 16'h2222, 16'h0000, 32'h32323232};
      vt[8] = '{1'b0, 1'b0, 16'h5050, 16'h0000, 16'h0000, 32'h35303530};

      lo = 1'b0;
      alm4 = 16'h0000; cur4 = 16'h1234; key4 = 16'h0000;
      sa4 = 1'b0; snt4 = 1'b0; stop4 = 1'b0;
      alm6 = 24'h000000; cur6 = 24'h123456; key6 = 24'h000000;
      alm1 = 4'h0; cur1 = 4'h7; key1 = 4'h0;

      // Reset values
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #10;
      chk("rst_disp4", {32'h0, disp4}, 64'h30303030);
      chk("rst_snd4", {63'h0, snd4}, 64'h0);
      chk("rst_disp6", {16'h0, disp6}, 64'h303030303030);
      chk("rst_disp1", {56'h0, disp1}, 64'h30);
      @(posedge clock);
      #1 reset_n = 1'b1;

      // Display selection / encoding table
      for (int i = 0; i < 9; i++) begin
         sa4 = vt[i].sa; snt4 = vt[i].snt;
         cur4 = vt[i].cur; alm4 = vt[i].alm; key4 = vt[i].key;
         push($sformatf("vec%0d_disp4", i), 0, {32'h0, vt[i].exp});
         push($sformatf("vec%0d_snd4", i), 1, 64'h0);
         if (i == 0) begin
            push("d6_time", 2, 64'h313233343536);
            push("d1_time", 4, 64'h37);
         end
         cycle();
      end

      // Blink: 4 on, 4 off; re-entry restarts with a visible frame
      sa4 = 1'b0; snt4 = 1'b0; cur4 = 16'h1234; alm4 = 16'h0000; key4 = 16'h0A59;
      push("pre_blink", 0, 64'h31323334);
      cycle();
      sa4 = 1'b1; snt4 = 1'b1;
      for (int k = 0; k < 6; k++) begin
         push($sformatf("blink_a%0d", k), 0,
              (((k / 4) % 2) == 0) ? 64'h302A3539 : 64'h20202020);
         cycle();
      end
      sa4 = 1'b0; snt4 = 1'b0;
      push("blink_exit", 0, 64'h31323334);
      cycle();
      sa4 = 1'b1; snt4 = 1'b1;
      for (int k = 0; k < 10; k++) begin
         push($sformatf("blink_b%0d", k), 0,
              (((k / 4) % 2) == 0) ? 64'h302A3539 : 64'h20202020);
         cycle();
      end
      sa4 = 1'b0; snt4 = 1'b0;

      // Alarm by counting up to the alarm time, all three widths
      alm4 = 16'h0700; alm6 = 24'h000700; alm1 = 4'h7;
      for (int k = 0; k < 3; k++) begin
         cur4 = 16'h0657 + 16'(k); cur6 = 24'h000657 + 24'(k); cur1 = 4'h4 + 4'(k);
         push_snd($sformatf("count%0d", k), 1'b0, 1'b0, 1'b0);
         cycle();
      end
      cur4 = 16'h0700; cur6 = 24'h000700; cur1 = 4'h7;
      for (int k = 0; k < 20; k++) begin
         if (k == 0) push("alarm_disp4", 0, 64'h30373030);
         push_snd($sformatf("alarm%0d", k), k < 10, k < 10, k < 10);
         cycle();
      end
      cur4 = 16'h0701; cur6 = 24'h000701; cur1 = 4'h8;
      push_snd("alarm_fall", 1'b0, 1'b0, 1'b0);
      cycle();

      // Stop on the third alarm cycle
      cur4 = 16'h0700;
      for (int k = 1; k <= 3; k++) begin
         push($sformatf("stop_run%0d", k), 1, 64'h1);
         cycle();
      end
      stop4 = 1'b1;
      push("stop_now", 1, 64'h0);
      cycle();
      stop4 = 1'b0;
      push("stop_after", 1, 64'h0);
      cycle();
      cur4 = 16'h0701;
      push("stop_fall", 1, 64'h0);
      cycle();
      cur4 = 16'h0700; stop4 = 1'b1;
      push("stop_coinc", 1, 64'h0);
      cycle();
      stop4 = 1'b0;
      push("stop_coinc_a", 1, 64'h0);
      cycle();
      push("stop_coinc_b", 1, 64'h0);
      cycle();

      // New rising edge while sounding restarts the full count
      cur4 = 16'h0701;
      push("rs_idle", 1, 64'h0);
      cycle();
      cur4 = 16'h0700;
      for (int k = 1; k <= 5; k++) begin
         push($sformatf("rs_first%0d", k), 1, 64'h1);
         cycle();
      end
      cur4 = 16'h0701;
      push("rs_gap", 1, 64'h1);
      cycle();
      cur4 = 16'h0700;
      for (int k = 0; k < 10; k++) begin
         push($sformatf("rs_second%0d", k), 1, 64'h1);
         cycle();
      end
      push("rs_end", 1, 64'h0);
      cycle();

      // Reset asserted mid-alarm acts immediately; equal times through release do not trigger
      cur4 = 16'h0701; cur6 = 24'h000701; cur1 = 4'h8;
      cycle();
      cur4 = 16'h0700; cur6 = 24'h000700; cur1 = 4'h7;
      push_snd("mid_a", 1'b1, 1'b1, 1'b1);
      cycle();
      push("mid_b", 1, 64'h1);
      cycle();
      #2 reset_n = 1'b0;
      #1;
      chk("async_snd4", {63'h0, snd4}, 64'h0);
      chk("async_disp4", {32'h0, disp4}, 64'h30303030);
      chk("async_snd6", {63'h0, snd6}, 64'h0);
      chk("async_disp1", {56'h0, disp1}, 64'h30);
      cycle();
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k == 0) push("rel_disp4", 0, 64'h30373030);
         push_snd($sformatf("rel%0d", k), 1'b0, 1'b0, 1'b0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_driver_n.md
LCD_DRIVER_N -- requirements
Module: lcd_driver_n

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of 4-bit BCD digits handled (legal range 1..8).
REQ-002 SHALL have parameter BLINK_DIV, default 250: clock cycles per blink half-period in key mode (legal range >=2).
REQ-003 SHALL have parameter ALARM_CYCLES, default 1000: maximum cycles sound_alarm stays asserted (legal range >=1).
REQ-004 SHALL have port clock  input  1  the only clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port alarm_time  input  4*NUM_DIGITS  alarm digits, digit 0 in bits [3:0] (least significant minute).
REQ-007 SHALL have port current_time  input  4*NUM_DIGITS  current-time digits, same packing.
REQ-008 SHALL have port key  input  4*NUM_DIGITS  keypad-entered digits, same packing.
REQ-009 SHALL have port show_alarm  input  1  request alarm-time display.
REQ-010 SHALL have port show_new_time  input  1  request key-entry display.
REQ-011 SHALL have port stop_alarm  input  1  user silence request.
REQ-012 SHALL have port display_time  output  8*NUM_DIGITS  ASCII code per digit, digit i in bits [8i+7:8i].
REQ-013 SHALL have port sound_alarm  output  1  alarm buzzer enable.

Function
REQ-014 SHALL run a 3-state display FSM: S_TIME, S_ALARM, S_KEY, evaluated every cycle.
REQ-015 SHALL go to S_KEY when show_new_time=1 (regardless of show_alarm), to S_ALARM when show_new_time=0 and show_alarm=1, else to S_TIME.
REQ-016 SHALL register display_time: the value reflects the source selected by the state entered on the same edge, i.e. 1-cycle latency from inputs.
REQ-017 SHALL encode each digit d in 0..9 as 8'h30+d, and any d in 10..15 as 8'h2A ('*').
REQ-018 SHALL, in S_KEY, blink the display: a blink counter counts 0..BLINK_DIV-1 and the phase toggles on wrap; phase on -> encoded key digits, phase off -> 8'h20 on every digit.
REQ-019 SHALL reset the blink counter to 0 and the phase to on upon every entry into S_KEY, so the first displayed key frame is visible.
REQ-020 SHALL hold the blink counter at 0 while not in S_KEY.
REQ-021 SHALL compute match = (alarm_time == current_time) over all NUM_DIGITS digits, and register it as match_d.
REQ-022 SHALL assert sound_alarm on the edge following a rising edge of match (match=1, match_d=0), and load the alarm counter with ALARM_CYCLES-1.
REQ-023 SHALL NOT retrigger while match remains continuously 1; a new trigger requires match to fall and rise again.
REQ-024 SHALL decrement the alarm counter each cycle while sound_alarm=1 and deassert sound_alarm when the counter is 0, giving exactly ALARM_CYCLES cycles high.
REQ-025 SHALL deassert sound_alarm on the edge after stop_alarm=1; stop_alarm SHALL take priority over a simultaneous match rising edge (no trigger that cycle).
REQ-026 SHALL restart the ALARM_CYCLES count if a new rising edge of match occurs while sound_alarm is already 1 and stop_alarm=0.
REQ-027 SHALL keep alarm logic independent of the display FSM: the alarm sounds in any state.

Reset
REQ-028 SHALL, while reset_n=0, force state=S_TIME, display_time = 8'h30 on every digit, sound_alarm=0, match_d=1, alarm counter=0, blink counter=0, phase=on.
REQ-029 SHALL, with match_d reset to 1, never trigger on the first cycle after reset even if alarm_time equals current_time.
REQ-030 SHALL, on reset assertion mid-alarm or mid-blink, abort immediately (asynchronously) to reset values.

Structure
REQ-031 SHALL take from shared package lcd_pkg: state encoding typedef, constants ASCII_ZERO=8'h30, ASCII_ERR=8'h2A, ASCII_BLANK=8'h20.
REQ-032 SHALL instantiate a combinational sub-module lcd_digit_enc (4-bit BCD in, 8-bit ASCII out) NUM_DIGITS times via generate; all registers live in lcd_driver_n.

Verification
REQ-033 SHALL test: NUM_DIGITS=4, current_time=16'h1234, no show inputs -> display_time=32'h31323334 one cycle later.
REQ-034 SHALL test: show_alarm=1 and show_new_time=1, key=16'h0A59 -> S_KEY, display 32'h302A3539 for BLINK_DIV=4 cycles, then 32'h20202020 for 4 cycles, repeating.
REQ-035 SHALL test: alarm_time=current_time=16'h0700 reached by counting -> sound_alarm high exactly ALARM_CYCLES=10 cycles, with no retrigger while equal.
REQ-036 SHALL test: stop_alarm pulsed on 3rd cycle of alarm -> sound_alarm low next edge; stop_alarm coincident with match rise -> sound_alarm stays 0.
REQ-037 SHALL test: alarm_time==current_time held through reset release -> sound_alarm stays 0; reset_n pulsed low mid-alarm -> sound_alarm=0 and display=32'h30303030 immediately.
REQ-038 SHALL test: NUM_DIGITS=6 and NUM_DIGITS=1 elaborations pass REQ-033 and REQ-035 equivalents.
